// File: rtl/within_seq_pkg.sv
// Shared types and helpers for the a/b/c/d within-window stimulus generator.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package within_seq_pkg;

  // Explicit encodings keep state values stable for anyone probing the raw register.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_PH   = 3'd1,
    GAP_PH = 3'd2,
    B_PH   = 3'd3,
    TAIL   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Reference window length in cycles: a phase, idle gap, then b phase.
  function automatic int win_len(input int a_len, input int gap_len, input int b_len);
    return a_len + gap_len + b_len;
  endfunction

endpackage

// File: rtl/within_pulse_sched.sv
// Pulse scheduler: emits C_PULSES pulses on c, then D_PULSES on d, at start_off + k*spacing.
// Latency: c/d are registered; a pulse at window cycle w is visible in that same window cycle.
// Backpressure: none; pulses are driven only while the top reports the next cycle as active.
module within_pulse_sched #(
  parameter int C_PULSES = 2,
  parameter int D_PULSES = 2,
  parameter int CNT_W    = 4,
  parameter int WIN_LEN  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] start_off,
  input  logic [CNT_W-1:0] spacing,
  input  logic             run_nxt,
  input  logic [CNT_W-1:0] win_cnt,
  output logic             c,
  output logic             d,
  output logic             pulse_last,
  output logic             overrun
);

  localparam int N_PULSES = C_PULSES + D_PULSES;
  localparam int IDX_W    = $clog2(N_PULSES + 1);
  localparam int OFF_W    = CNT_W + IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_N    = IDX_W'(N_PULSES);
  localparam logic [IDX_W-1:0] IDX_C    = IDX_W'(C_PULSES);
  localparam logic [OFF_W-1:0] WIN_LAST = OFF_W'(WIN_LEN - 1);
  localparam logic [OFF_W-1:0] K_LAST   = OFF_W'(N_PULSES - 1);

  logic [CNT_W-1:0] cd_q, cd_d;     // cycles from the current cycle to the next pulse
  logic [CNT_W-1:0] sp_q, sp_d;     // latched effective spacing
  logic [IDX_W-1:0] idx_q, idx_d;   // pulses emitted so far, including the current cycle
  logic             ovr_q, ovr_d;
  logic             c_q, c_d, d_q, d_d;
  logic [CNT_W-1:0] sp_in_eff, cd_nxt;
  logic [IDX_W-1:0] idx_cur;
  logic [OFF_W-1:0] last_off;
  logic             fire;

  // Decide whether the upcoming cycle carries a pulse; countdown saturates at zero.
  always_comb begin
    sp_in_eff = (spacing == '0) ? CNT_W'(1) : spacing;
    last_off  = OFF_W'(start_off) + OFF_W'(sp_in_eff) * K_LAST;
    cd_nxt    = load ? start_off : ((cd_q == '0) ? cd_q : cd_q - CNT_W'(1));
    idx_cur   = load ? '0 : idx_q;
    fire      = run_nxt && (idx_cur < IDX_N) && (cd_nxt == '0);
    cd_d      = fire ? (load ? sp_in_eff : sp_q) : cd_nxt;
    idx_d     = fire ? idx_cur + IDX_W'(1) : idx_cur;
    sp_d      = load ? sp_in_eff : sp_q;
    ovr_d     = load ? (last_off > WIN_LAST) : ovr_q;
    c_d       = fire && (idx_cur < IDX_C);
    d_d       = fire && (idx_cur >= IDX_C);
  end

  // Schedule state and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q  <= '0;
      sp_q  <= '0;
      idx_q <= '0;
      ovr_q <= 1'b0;
      c_q   <= 1'b0;
      d_q   <= 1'b0;
    end else begin
      cd_q  <= cd_d;
      sp_q  <= sp_d;
      idx_q <= idx_d;
      ovr_q <= ovr_d;
      c_q   <= c_d;
      d_q   <= d_d;
    end
  end

  // A saturated window counter truncates whatever is left of the train.
  assign pulse_last = (idx_q == IDX_N) || (win_cnt == CNT_MAX);
  assign c          = c_q;
  assign d          = d_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/within_seq_gen.sv
// Stimulus generator: a/b reference window with an embedded c-then-d pulse train.
// Latency: start accepted at edge T gives a=1 (window cycle 0) from T+1; all outputs registered.
// Backpressure: start is ignored unless IDLE; no queueing of requests.
module within_seq_gen
  import within_seq_pkg::*;
#(
  parameter int A_LEN    = 4,
  parameter int GAP_LEN  = 2,
  parameter int B_LEN    = 2,
  parameter int C_PULSES = 2,
  parameter int D_PULSES = 2,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] start_off,
  input  logic [CNT_W-1:0] spacing,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int WIN_LEN = win_len(A_LEN, GAP_LEN, B_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] A_END   = CNT_W'(A_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] B_END   = CNT_W'(B_LEN - 1);

  if (WIN_LEN > (2 ** CNT_W) - 1 || A_LEN < 1 || B_LEN < 1 || GAP_LEN < 0 ||
      C_PULSES < 1 || D_PULSES < 1) begin : g_param_check
    $error("within_seq_gen: window does not fit CNT_W or phase/pulse count illegal");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;     // cycle index within the current phase
  logic [CNT_W-1:0] win_q, win_d;   // window cycle of the current cycle, saturating
  logic             a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic             accept, run_nxt, pulse_last, sched_ovr;

  // Phase sequencing; window counter advances in every active cycle and saturates.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    win_d   = win_q;
    accept  = 1'b0;
    if (state_q inside {A_PH, GAP_PH, B_PH, TAIL}) begin
      win_d = (win_q == CNT_MAX) ? win_q : win_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = A_PH;
          ph_d    = '0;
          win_d   = '0;
        end
      end
      A_PH: begin
        if (ph_q == A_END) begin
          ph_d    = '0;
          state_d = (GAP_LEN == 0) ? B_PH : GAP_PH;
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
      GAP_PH: begin
        if (ph_q == GAP_END) begin
          ph_d    = '0;
          state_d = B_PH;
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
      B_PH: begin
        if (ph_q == B_END) begin
          ph_d    = '0;
          state_d = pulse_last ? DONE : TAIL;
        end else begin
          ph_d = ph_q + CNT_W'(1);
        end
      end
      TAIL: begin
        if (pulse_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        ph_d    = '0;
        win_d   = '0;
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
        win_d   = '0;
      end
    endcase
    run_nxt = state_d inside {A_PH, GAP_PH, B_PH, TAIL};
    a_d     = (state_d == A_PH);
    b_d     = (state_d == B_PH);
    busy_d  = run_nxt;
    done_d  = (state_d == DONE);
    ovr_d   = (state_d == DONE) && sched_ovr;
  end

  // FSM, counters and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      win_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  within_pulse_sched #(
    .C_PULSES (C_PULSES),
    .D_PULSES (D_PULSES),
    .CNT_W    (CNT_W),
    .WIN_LEN  (WIN_LEN)
  ) u_sched (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .start_off  (start_off),
    .spacing    (spacing),
    .run_nxt    (run_nxt),
    .win_cnt    (win_q),
    .c          (c),
    .d          (d),
    .pulse_last (pulse_last),
    .overrun    (sched_ovr)
  );

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_within_seq_gen.sv
// Self-checking bench for within_seq_gen: per-cycle expected output vectors queued on stimulus.
// Latency: expected trace starts the cycle after the accepting edge.
// Backpressure: exercises held start (ignored while busy) and mid-sequence reset.
module tb_within_seq_gen;

  localparam int A_LEN = 4, GAP_LEN = 2, B_LEN = 2, C_P = 2, D_P = 2, CNT_W = 4;
  localparam int WIN = A_LEN + GAP_LEN + B_LEN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] start_off = '0;
  logic [CNT_W-1:0] spacing = '0;
  logic             a, b, c, d, busy, done, overrun;
  logic [6:0]       obs_vec;
  logic [6:0]       exp_v;
  logic [6:0]       exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;

  assign obs_vec = {a, b, c, d, busy, done, overrun};

  within_seq_gen #(
    .A_LEN(A_LEN), .GAP_LEN(GAP_LEN), .B_LEN(B_LEN),
    .C_PULSES(C_P), .D_PULSES(D_P), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_off(start_off), .spacing(spacing),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference model: expected {a,b,c,d,busy,done,overrun} per cycle, window cycle 0 first,
  // then the done cycle, then one idle cycle.
  task automatic push_seq(input int off, input int sp);
    int spe, plast, last;
    logic [6:0] e;
    spe   = (sp == 0) ? 1 : sp;
    plast = off + (C_P + D_P - 1) * spe;
    last  = (plast > WIN - 1) ? plast : WIN - 1;
    for (int w = 0; w <= last + 2; w++) begin
      e = '0;
      if (w <= last) begin
        e[6] = (w < A_LEN);
        e[5] = (w >= A_LEN + GAP_LEN) && (w < WIN);
        for (int k = 0; k < C_P + D_P; k++) begin
          if (off + k * spe == w) begin
            if (k < C_P) e[4] = 1'b1;
            else         e[3] = 1'b1;
          end
        end
        e[2] = 1'b1;
      end else if (w == last + 1) begin
        e[1] = 1'b1;
        e[0] = (plast > WIN - 1);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== 7'b0) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %b required %b", i, obs_vec, 7'b0);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    start_off = 4'd1; spacing = 4'd2; start = 1'b1;
    push_seq(1, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL nominal cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
    end
  endtask

  task automatic test_zero_offset();
    start_off = 4'd0; spacing = 4'd1; start = 1'b1;
    push_seq(0, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL zero_offset cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
    end
  endtask

  task automatic test_overrun();
    start_off = 4'd3; spacing = 4'd2; start = 1'b1;
    push_seq(3, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL overrun cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
    end
  endtask

  task automatic test_spacing_zero();
    start_off = 4'd2; spacing = 4'd0; start = 1'b1;
    push_seq(2, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL spacing_zero cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_off = 4'd1; spacing = 4'd2; start = 1'b1;
    push_seq(1, 2);
    push_seq(1, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
      if (exp_q.size() <= 2) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    start_off = 4'd1; spacing = 4'd2; start = 1'b1;
    push_seq(1, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_pre cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (obs_vec !== 7'b0) begin
        n_err++;
        $display("FAIL reset_mid_quiet cyc%0d: got %b required %b", i, obs_vec, 7'b0);
      end
      @(negedge clk);
    end
    start_off = 4'd1; spacing = 4'd2; start = 1'b1;
    push_seq(1, 2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs_vec !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_restart cyc%0d: got %b required %b", i, obs_vec, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_offset();
    test_overrun();
    test_spacing_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
